// File: rtl/ex_muldiv_unit_if.sv
// EX-stage mul/div handshake bundle: instruction request in, stall/status and HI/LO out.
// Pure wiring; the master modport is the pipeline side, the slave modport is the unit.
interface ex_muldiv_unit_if #(
   parameter int DATA_W = 32
);
   logic              flush;
   logic              start;
   logic [2:0]        op;
   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] src_b;
   logic              stall_req;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport master (
      output flush, start, op, src_a, src_b,
      input  stall_req, busy, done, hi, lo
   );

   modport slave (
      input  flush, start, op, src_a, src_b,
      output stall_req, busy, done, hi, lo
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; N = DATA_W/BITS_PER_CYC iterations, done in cycle N+1.
// Stalls the pipeline combinationally from the start cycle until the result is written; flush aborts.
module ex_muldiv_unit #(
   parameter int DATA_W       = 32,
   parameter int BITS_PER_CYC = 1
) (
   input  logic               clk,
   input  logic               rst,
   ex_muldiv_unit_if.slave    bus
);
   localparam int N  = DATA_W / BITS_PER_CYC;
   localparam int CW = $clog2(N) + 1;

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t              state, state_nxt;
   logic [2*DATA_W-1:0] acc;
   logic [DATA_W-1:0]   opd;
   logic [CW-1:0]       cnt;
   logic                neg_lo, neg_hi, div_zero;

   logic                is_mul, is_div, signed_op, sa, sb, last;
   logic [DATA_W-1:0]   a_mag, b_mag;
   logic [2*DATA_W:0]   mt;
   logic [2*DATA_W-1:0] dv;
   logic [DATA_W:0]     trial;
   logic [2*DATA_W-1:0] prod_fin;
   logic [DATA_W-1:0]   quo_fin, rem_fin;

   assign is_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
   assign is_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
   assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign sa        = signed_op & bus.src_a[DATA_W-1];
   assign sb        = signed_op & bus.src_b[DATA_W-1];
   assign a_mag     = sa ? -bus.src_a : bus.src_a;
   assign b_mag     = sb ? -bus.src_b : bus.src_b;
   assign last      = (cnt == CW'(N - 1));

   // One iteration's worth of shift-add and restoring-divide steps, unrolled.
   // mul: acc = {partial product, remaining multiplier}; div: acc = {remainder, remaining dividend/quotient}.
   always_comb begin
      mt    = {1'b0, acc};
      dv    = acc;
      trial = '0;
      for (int j = 0; j < BITS_PER_CYC; j++) begin
         if (mt[0])
            mt[2*DATA_W:DATA_W] = {1'b0, mt[2*DATA_W-1:DATA_W]} + {1'b0, opd};
         mt = mt >> 1;

         trial = dv[2*DATA_W-1:DATA_W-1] - {1'b0, opd};
         dv    = dv << 1;
         if (!trial[DATA_W])
            dv = {trial[DATA_W-1:0], dv[DATA_W-1:1], 1'b1};
      end
   end

   // A zero divisor yields all-ones quotient; the remainder sign fix restores src_a.
   assign prod_fin = neg_lo ? -mt[2*DATA_W-1:0] : mt[2*DATA_W-1:0];
   assign quo_fin  = div_zero ? '1 : (neg_lo ? -dv[DATA_W-1:0] : dv[DATA_W-1:0]);
   assign rem_fin  = neg_hi ? -dv[2*DATA_W-1:DATA_W] : dv[2*DATA_W-1:DATA_W];

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start && is_mul)
                  state_nxt = S_MUL;
               else if (bus.start && is_div)
                  state_nxt = S_DIV;
            end
            S_MUL:   if (last) state_nxt = S_DONE;
            S_DIV:   if (last) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.busy      = (state != S_IDLE);
      bus.done      = (state == S_DONE);
      bus.stall_req = ((state == S_IDLE) && bus.start && (is_mul || is_div)) ||
                      (state == S_MUL) || (state == S_DIV);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.hi   <= '0;
         bus.lo   <= '0;
         acc      <= '0;
         opd      <= '0;
         cnt      <= '0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         div_zero <= 1'b0;
      end else if (!bus.flush) begin
         case (state)
            S_IDLE: begin
               if (bus.start && is_mul) begin
                  acc    <= {{DATA_W{1'b0}}, b_mag};
                  opd    <= a_mag;
                  cnt    <= '0;
                  neg_lo <= sa ^ sb;
                  neg_hi <= 1'b0;
               end else if (bus.start && is_div) begin
                  acc      <= {{DATA_W{1'b0}}, a_mag};
                  opd      <= b_mag;
                  cnt      <= '0;
                  neg_lo   <= sa ^ sb;
                  neg_hi   <= sa;
                  div_zero <= (bus.src_b == '0);
               end else if (bus.start && bus.op == OP_MTHI) begin
                  bus.hi <= bus.src_a;
               end else if (bus.start && bus.op == OP_MTLO) begin
                  bus.lo <= bus.src_a;
               end
            end
            S_MUL: begin
               acc <= mt[2*DATA_W-1:0];
               cnt <= cnt + CW'(1);
               if (last)
                  {bus.hi, bus.lo} <= prod_fin;
            end
            S_DIV: begin
               acc <= dv;
               cnt <= cnt + CW'(1);
               if (last) begin
                  bus.hi <= rem_fin;
                  bus.lo <= quo_fin;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
